// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides CLK down to a pixel strobe and produces
// registered sync, blanking and coordinate outputs for a configurable mode.
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start
);

  localparam int unsigned HTotal     = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal     = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSyncStart = H_DISPLAY + H_FP;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC - 1;
  localparam int unsigned VSyncStart = V_DISPLAY + V_FP;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC - 1;
  localparam int unsigned DivW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] div_q, div_d;
  logic            tick_q;
  logic [9:0]      h_q, h_d, v_q, v_d;
  logic            h_wrap, v_wrap;
  logic            hsync_q, vsync_q, video_on_q, frame_start_q;

  always_comb begin
    div_d  = (div_q == DivW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
    h_wrap = (h_q == 10'(HTotal - 1));
    v_wrap = (v_q == 10'(VTotal - 1));
    h_d    = h_q;
    v_d    = v_q;
    if (tick_q) begin
      h_d = h_wrap ? '0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 10'd1;
      end
    end
  end

  // Sync/blank flags are derived from the next position so they line up with pix_x/pix_y.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_q         <= '0;
      tick_q        <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      tick_q        <= (div_d == DivW'(CLK_DIV - 1));
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= !((h_d >= 10'(HSyncStart)) && (h_d <= 10'(HSyncEnd)));
      vsync_q       <= !((v_d >= 10'(VSyncStart)) && (v_d <= 10'(VSyncEnd)));
      video_on_q    <= (h_d < 10'(H_DISPLAY)) && (v_d < 10'(V_DISPLAY));
      frame_start_q <= tick_q && h_wrap && v_wrap;
    end
  end

  assign p_tick      = tick_q;
  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, SHALL be the number of visible pixels per line.
REQ-002 Parameter H_FP, default 16, SHALL be the horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, SHALL be the horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, SHALL be the horizontal back porch in pixels.
REQ-005 Parameter V_DISPLAY, default 480, SHALL be the number of visible lines per frame.
REQ-006 Parameter V_FP, default 10, SHALL be the vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, SHALL be the vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, SHALL be the vertical back porch in lines.
REQ-009 Parameter CLK_DIV, default 4, SHALL be the number of CLK cycles per pixel (4 gives 25 MHz from 100 MHz).
REQ-010 CLK  input  1  SHALL be the system clock; the block has only this one clock.
REQ-011 RESET  input  1  SHALL be a synchronous, active-high reset.
REQ-012 hsync  output  1  SHALL be the horizontal sync, active low.
REQ-013 vsync  output  1  SHALL be the vertical sync, active low.
REQ-014 video_on  output  1  SHALL be high while the current pixel is in the visible area.
REQ-015 p_tick  output  1  SHALL be a one-CLK pixel-enable strobe.
REQ-016 pix_x  output  10  SHALL be the current horizontal pixel coordinate.
REQ-017 pix_y  output  10  SHALL be the current vertical line coordinate.
REQ-018 frame_start  output  1  SHALL be a one-CLK strobe marking the first pixel of a frame.

Function
REQ-019 The divider counter SHALL count 0..CLK_DIV-1 and then wrap to 0; p_tick SHALL be 1 exactly in the cycle where the divider equals CLK_DIV-1.
REQ-020 The horizontal counter SHALL advance only on p_tick and SHALL wrap from H_TOTAL-1 to 0, where H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800).
REQ-021 The vertical counter SHALL advance only on a p_tick that coincides with the horizontal wrap, and SHALL wrap from V_TOTAL-1 to 0, where V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525).
REQ-022 On a p_tick where h=799 and v=524, both counters SHALL go to 0 in the same edge.
REQ-023 pix_x and pix_y SHALL be the registered counter values, with no extra latency.
REQ-024 hsync SHALL be registered, computed from the next h value, and SHALL be 0 exactly while pix_x is in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1] ([656,751]).
REQ-025 vsync SHALL be registered, computed from the next v value, and SHALL be 0 exactly while pix_y is in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1] ([490,491]).
REQ-026 video_on SHALL be 1 if and only if pix_x < H_DISPLAY and pix_y < V_DISPLAY, aligned with pix_x and pix_y.
REQ-027 frame_start SHALL be 1 for one CLK in the cycle after the edge that loads pix_x=0 and pix_y=0 from the wrap.
REQ-028 Counter widths SHALL be 10 bits; the counters SHALL never reach H_TOTAL or V_TOTAL.
REQ-029 Outputs SHALL hold their values between p_ticks.

Reset
REQ-030 While RESET=1 at a CLK edge, the divider, pix_x and pix_y SHALL be 0, hsync=1, vsync=1, p_tick=0 and frame_start=0; video_on SHALL be 1.
REQ-031 A reset asserted mid-frame SHALL take effect on the next CLK edge and discard the current position.
REQ-032 After reset deasserts, the first p_tick SHALL occur CLK_DIV cycles later, and the first advance SHALL be to pix_x=1.
REQ-033 No frame_start SHALL be produced by the reset itself.

Verification
REQ-034 Release reset, count CLK cycles between p_ticks -> exactly 4, and p_tick is high for 1 cycle.
REQ-035 Run one line -> pix_x runs 0..799 and wraps; hsync is low for exactly 96 pixels starting at pix_x=656; video_on falls at pix_x=640.
REQ-036 Run a full frame -> 420000 pixels (800x525), i.e. 1,680,000 CLK cycles; vsync is low for pix_y 490-491 only (1600 pixels); frame_start fires once per frame, at pix_x=0 and pix_y=0.
REQ-037 Corner at h=799, v=524 -> the next p_tick gives pix_x=0 and pix_y=0, video_on=1, and frame_start=1 one cycle later.
REQ-038 Assert RESET at pix_x=700, pix_y=300 for 1 cycle -> the next edge gives pix_x=0, pix_y=0, hsync=1, vsync=1, and there is no frame_start pulse.
REQ-039 Check on every p_tick -> pix_x < 800, pix_y < 525, and video_on equals (pix_x<640 && pix_y<480).
